ped_signal: RTL



---
 rtl/ped_signal_pkg.sv | 20 ++
 rtl/ped_signal_bin2bcd.sv | 26 ++
 rtl/ped_signal.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ped_signal_pkg.sv
// Shared definitions for the pedestrian crossing controller: vehicle phase codes,
// pedestrian FSM encoding and the display clamp value.
package ped_signal_pkg;

    // Phase codes are shared with the upstream vehicle controller; code 3 is illegal.
    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        ST_DONT_WALK = 2'd0,
        ST_WALK      = 2'd1,
        ST_CLEAR     = 2'd2
    } ped_state_e;

    localparam logic [7:0] DISP_MAX = 8'd99;

endpackage

// File: rtl/ped_signal_bin2bcd.sv
// Combinational 8-bit binary to two-digit BCD, clamped to DISP_MAX (double-dabble).
module ped_signal_bin2bcd
    import ped_signal_pkg::*;
(
    input  logic [7:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [7:0] clamped;
    logic [7:0] bcd;

    // The clamp keeps the value below 100, so no hundreds digit is ever needed.
    always_comb begin
        clamped = (bin > DISP_MAX) ? DISP_MAX : bin;
        bcd     = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            bcd = {bcd[6:0], clamped[i]};
        end
        tens = bcd[7:4];
        ones = bcd[3:0];
    end

endmodule

// File: rtl/ped_signal.sv
// Pedestrian WALK / flashing-CLEAR / DONT_WALK controller riding on the vehicle RED phase.
// Optional PED_PROPERTY_EN drives the p1/p2 property outputs; otherwise they are tied low.
module ped_signal
    import ped_signal_pkg::*;
#(
    parameter int CLEAR_TIME = 10,
    parameter int MIN_WALK   = 5,
    parameter int FLASH_HALF = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light,
    input  logic [7:0] time_left,
    input  logic       button,
    output logic       walk,
    output logic       dontwalk,
    output logic       req_pending,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_ones,
    output logic       p1,
    output logic       p2
);

    localparam int         CW            = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [8:0] WALK_MIN_LEFT = 9'(CLEAR_TIME + MIN_WALK);
    localparam logic [8:0] CLEAR_AT      = 9'(CLEAR_TIME);
    localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_HALF - 1);

    ped_state_e    state_q, state_d;
    logic          walk_q, walk_d;
    logic          dontwalk_q, dontwalk_d;
    logic          req_q, req_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [CW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_phase_q, flash_phase_d;

    logic       is_red;
    logic       start_walk;
    logic [8:0] time_left_w;
    logic [3:0] bcd_tens, bcd_ones;

    ped_signal_bin2bcd u_bin2bcd (
        .bin  (time_left),
        .tens (bcd_tens),
        .ones (bcd_ones)
    );

    always_comb begin
        is_red      = (light == PH_RED);
        time_left_w = {1'b0, time_left};
        start_walk  = 1'b0;
        state_d     = state_q;

        // Leaving RED (including the illegal code) always wins.
        case (state_q)
            ST_DONT_WALK: begin
                if (is_red && req_q && (time_left_w >= WALK_MIN_LEFT)) begin
                    state_d    = ST_WALK;
                    start_walk = 1'b1;
                end
            end
            ST_WALK: begin
                if (!is_red)                       state_d = ST_DONT_WALK;
                else if (time_left_w <= CLEAR_AT)  state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (!is_red) state_d = ST_DONT_WALK;
            end
            default: state_d = ST_DONT_WALK;
        endcase

        flash_cnt_d   = '0;
        flash_phase_d = 1'b1;
        if ((state_q == ST_CLEAR) && (state_d == ST_CLEAR)) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_cnt_d   = '0;
                flash_phase_d = ~flash_phase_q;
            end else begin
                flash_cnt_d   = flash_cnt_q + 1'b1;
                flash_phase_d = flash_phase_q;
            end
        end

        req_d = req_q;
        if (start_walk)
            req_d = 1'b0;
        else if (button && (state_q != ST_WALK))
            req_d = 1'b1;

        walk_d     = (state_d == ST_WALK);
        dontwalk_d = (state_d == ST_CLEAR) ? flash_phase_d : (state_d == ST_DONT_WALK);

        if (state_d == ST_DONT_WALK) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else begin
            tens_d = bcd_tens;
            ones_d = bcd_ones;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_DONT_WALK;
            walk_q        <= 1'b0;
            dontwalk_q    <= 1'b1;
            req_q         <= 1'b0;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            walk_q        <= walk_d;
            dontwalk_q    <= dontwalk_d;
            req_q         <= req_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
        end
    end

    assign walk        = walk_q;
    assign dontwalk    = dontwalk_q;
    assign req_pending = req_q;
    assign digit_tens  = tens_q;
    assign digit_ones  = ones_q;

`ifdef PED_PROPERTY_EN
    logic [1:0] light_q;

    always_ff @(posedge clk) begin
        if (!reset) light_q <= PH_RED;
        else        light_q <= light;
    end

    assign p1 = walk_q && (light_q != PH_RED);
    assign p2 = walk_q && dontwalk_q;
`else
    assign p1 = 1'b0;
    assign p2 = 1'b0;
`endif

endmodule
